// File: rtl/dec_scan_n.sv
// dec_scan_n: registered N-to-2^N decoder with active-low enable.
// Direct mode decodes sel one cycle later. Scan mode walks every output
// in turn, holding each for DWELL cycles with an optional BLANK gap.
// All outputs come straight from flops, so data is glitch-free and one-hot
// (or one-cold) by construction.
module dec_scan_n #(
  parameter int SEL_W      = 2,
  parameter int OUT_W      = 2**SEL_W,
  parameter int ACTIVE_LOW = 1,
  parameter int DWELL      = 4,
  parameter int BLANK      = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_n,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  output logic [OUT_W-1:0] data,
  output logic [SEL_W-1:0] idx,
  output logic             wrap
);

  // Phase counter must reach max(DWELL, BLANK) - 1.
  localparam int MAXC  = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [SEL_W-1:0] IDX_LAST   = SEL_W'(OUT_W - 1);

  localparam logic [OUT_W-1:0] INACTIVE =
    (ACTIVE_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  // State is kept as a named enum so checkers can bind to dec_scan_n.state_q.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DIRECT     = 2'd1,
    SCAN_ON    = 2'd2,
    SCAN_BLANK = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] data_d;
  logic [SEL_W-1:0] idx_d;
  logic             wrap_d;
  logic [SEL_W-1:0] idx_next;

  // Single asserted output at position i, in the configured polarity.
  function automatic logic [OUT_W-1:0] drive(input logic [SEL_W-1:0] i);
    logic [OUT_W-1:0] oh;
    oh    = '0;
    oh[i] = 1'b1;
    return (ACTIVE_LOW != 0) ? ~oh : oh;
  endfunction

  // Round-robin successor; SEL_W-bit arithmetic wraps at OUT_W.
  assign idx_next = idx + SEL_W'(1);

  // State, counter and output registers; reset forces everything inactive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data    <= INACTIVE;
      idx     <= '0;
      wrap    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data    <= data_d;
      idx     <= idx_d;
      wrap    <= wrap_d;
    end
  end

  // Next state: enable beats mode; scan phases advance on their last count.
  always_comb begin
    state_d = state_q;
    if (en_n) begin
      state_d = IDLE;
    end else if (!mode) begin
      state_d = DIRECT;
    end else begin
      case (state_q)
        IDLE, DIRECT: state_d = SCAN_ON;
        SCAN_ON: begin
          if (cnt_q == DWELL_LAST) state_d = (BLANK > 0) ? SCAN_BLANK : SCAN_ON;
        end
        SCAN_BLANK: begin
          if (cnt_q == BLANK_LAST) state_d = SCAN_ON;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Next registered outputs, derived from the transition being taken.
  always_comb begin
    data_d = INACTIVE;
    idx_d  = '0;
    wrap_d = 1'b0;
    cnt_d  = '0;
    case (state_d)
      DIRECT: begin
        data_d = drive(sel);
        idx_d  = sel;
      end
      SCAN_ON: begin
        if (state_q == SCAN_ON && cnt_q != DWELL_LAST) begin
          // Still dwelling on the current output.
          data_d = drive(idx);
          idx_d  = idx;
          cnt_d  = cnt_q + CNT_W'(1);
        end else if (state_q == SCAN_ON || state_q == SCAN_BLANK) begin
          // Moving on to the next output; flag the frame restart.
          data_d = drive(idx_next);
          idx_d  = idx_next;
          wrap_d = (idx == IDX_LAST);
        end else begin
          // Fresh scan entry from IDLE or DIRECT: start at 0, no wrap.
          data_d = drive('0);
        end
      end
      SCAN_BLANK: begin
        idx_d = idx;
        if (state_q == SCAN_BLANK) cnt_d = cnt_q + CNT_W'(1);
      end
      default: begin
        data_d = INACTIVE;
      end
    endcase
  end

endmodule

// File: tb/tb_dec_scan_n.sv
// tb_dec_scan_n: drives three differently configured dec_scan_n instances
// with shared inputs and compares each against a cycle-count reference.
module tb_dec_scan_n;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       en_n  = 1'b1;
  logic       mode  = 1'b0;
  logic [2:0] sel   = '0;

  logic [3:0] data0, data1;
  logic [7:0] data2;
  logic [1:0] idx0, idx1;
  logic [2:0] idx2;
  logic       wrap0, wrap1, wrap2;

  int checks = 0;
  int errors = 0;

  // Clock
  always #5 clk = ~clk;

  // Main configuration: SEL_W=2, active-low, DWELL=3, BLANK=1
  dec_scan_n #(.SEL_W(2), .ACTIVE_LOW(1), .DWELL(3), .BLANK(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en_n(en_n), .mode(mode), .sel(sel[1:0]),
    .data(data0), .idx(idx0), .wrap(wrap0));

  // Fast rotation: DWELL=1, BLANK=0
  dec_scan_n #(.SEL_W(2), .ACTIVE_LOW(1), .DWELL(1), .BLANK(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en_n(en_n), .mode(mode), .sel(sel[1:0]),
    .data(data1), .idx(idx1), .wrap(wrap1));

  // Wide, active-high: SEL_W=3, DWELL=2, BLANK=0
  dec_scan_n #(.SEL_W(3), .ACTIVE_LOW(0), .DWELL(2), .BLANK(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en_n(en_n), .mode(mode), .sel(sel),
    .data(data2), .idx(idx2), .wrap(wrap2));

  // Reference model: per instance, an operating mode and the number of
  // cycles since scan entry; outputs follow from plain arithmetic.
  int c_selw[3] = '{2, 2, 3};
  int c_al[3]   = '{1, 1, 0};
  int c_dw[3]   = '{3, 1, 2};
  int c_bl[3]   = '{1, 0, 0};

  int m_mode[3];   // 0 idle, 1 direct, 2 scanning
  int m_t[3];      // cycles since scan entry
  int m_sel[3];

  logic [11:0] exp_q[$];   // {wrap, idx[2:0], data[7:0]}

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_mode[k] = 0;
      m_t[k]    = 0;
      m_sel[k]  = 0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      if (en_n) begin
        m_mode[k] = 0;
      end else if (!mode) begin
        m_mode[k] = 1;
        m_sel[k]  = int'(sel) % (1 << c_selw[k]);
      end else if (m_mode[k] == 2) begin
        m_t[k] = m_t[k] + 1;
      end else begin
        m_mode[k] = 2;
        m_t[k]    = 0;
      end
    end
  endtask

  function automatic logic [11:0] model_out(int k);
    int outw, per, p, ix, act, wr, dmask, dat;
    logic [11:0] r;
    outw  = 1 << c_selw[k];
    dmask = (1 << outw) - 1;
    ix    = 0;
    act   = 0;
    wr    = 0;
    if (m_mode[k] == 1) begin
      ix  = m_sel[k];
      act = 1 << ix;
    end else if (m_mode[k] == 2) begin
      per = c_dw[k] + c_bl[k];
      p   = m_t[k] % (outw * per);
      ix  = p / per;
      if ((p % per) < c_dw[k]) act = 1 << ix;
      wr  = (m_t[k] > 0 && p == 0) ? 1 : 0;
    end
    dat = (c_al[k] != 0) ? (~act & dmask) : act;
    r   = {1'(wr), 3'(ix), 8'(dat)};
    return r;
  endfunction

  function automatic logic [11:0] get_obs(int k);
    case (k)
      0:       return {wrap0, 1'b0, idx0, 4'b0, data0};
      1:       return {wrap1, 1'b0, idx1, 4'b0, data1};
      default: return {wrap2, idx2, data2};
    endcase
  endfunction

  // Scoreboard compare
  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    logic [11:0] e, o;
    for (int k = 0; k < 3; k++) exp_q.push_back(model_out(k));
    for (int k = 0; k < 3; k++) begin
      e = exp_q.pop_front();
      o = get_obs(k);
      check($sformatf("%s.data%0d", tag, k), o[7:0], e[7:0]);
      check($sformatf("%s.idx%0d", tag, k), {5'b0, o[10:8]}, {5'b0, e[10:8]});
      check($sformatf("%s.wrap%0d", tag, k), {7'b0, o[11]}, {7'b0, e[11]});
    end
  endtask

  // Driver: one clock, model update, sample 1 time unit after the edge.
  task automatic step(string tag);
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset pulse away from any clock edge.
  task automatic async_reset(string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all({tag, "_now"});
    @(posedge clk);
    #1;
    check_all({tag, "_hold"});
    rst_n = 1'b1;
  endtask

  logic [3:0] onehot;

  initial begin
    // Reset with no clock edge
    model_reset();
    #1 rst_n = 1'b0;
    #1 check_all("reset_async");
    check("reset_const", {4'b0, data0}, 8'h0f);
    step("reset_edge");
    rst_n = 1'b1;

    // Enable off
    en_n = 1'b1;
    step("idle");

    // Direct decode of 0..3
    en_n = 1'b0;
    mode = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel = 3'(s);
      step("direct");
      onehot = 4'b0001 << s;
      check("direct_const", {4'b0, data0}, {4'b0, ~onehot});
    end
    en_n = 1'b1;
    step("direct_off");
    check("direct_off_const", {4'b0, data0}, 8'h0f);

    // Wide active-high direct decode
    en_n = 1'b0;
    sel  = 3'd5;
    step("direct_sel5");
    check("sel5_const", data2, 8'h20);

    // Random direct selects, one per cycle
    for (int i = 0; i < 12; i++) begin
      sel = 3'($urandom_range(0, 7));
      step("direct_rand");
    end

    // Scan frame from IDLE
    en_n = 1'b1;
    step("pre_scan");
    en_n = 1'b0;
    mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step("scan");
      if (i == 0)  check("scan_entry_wrap", {7'b0, wrap0}, 8'h00);
      if (i == 4)  check("fast_wrap4", {7'b0, wrap1}, 8'h01);
      if (i == 16) check("scan_wrap16", {7'b0, wrap0}, 8'h01);
      if (i == 16) check("wide_wrap16", {7'b0, wrap2}, 8'h01);
    end

    // Enable drop during idx=2 dwell
    en_n = 1'b1;
    step("rescan_idle");
    en_n = 1'b0;
    for (int i = 0; i < 9; i++) step("rescan");
    en_n = 1'b1;
    step("int_en");
    check("int_en_const", {4'b0, data0}, 8'h0f);
    en_n = 1'b0;
    step("int_restart");
    check("int_restart_const", {4'b0, data0}, 8'h0e);

    // Mode drop during idx=2 dwell
    for (int i = 0; i < 9; i++) step("rescan2");
    mode = 1'b0;
    sel  = 3'd3;
    step("int_mode");
    check("int_mode_const", {4'b0, data0}, 8'h07);
    mode = 1'b1;
    for (int i = 0; i < 7; i++) step("int_mode_rescan");

    // Reset mid-scan
    async_reset("reset_mid");
    for (int i = 0; i < 6; i++) step("post_reset");

    // Randomized phases of enable, mode and select
    for (int i = 0; i < 400; i++) begin
      en_n = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 24) == 0) mode = ~mode;
      sel = 3'($urandom_range(0, 7));
      step("rand");
      if (i == 200) async_reset("reset_rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
